// File: rtl/ika87ad_irq_pkg.sv
// Shared types and helpers for the interrupt flag bank and arbiter.
// Holds the arbiter state enum, default sizes and the code-compare helper.
package ika87ad_irq_pkg;

  localparam int NCH_DEF   = 8;
  localparam int CODEW_DEF = 5;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_HELD = 1'b1
  } irq_state_e;

  // True when code addresses channel idx of a bank starting at base.
  // Codes below base or past the last channel never match.
  function automatic logic code_hit(
    input int unsigned code,
    input int unsigned base,
    input int unsigned idx
  );
    return code == (base + idx);
  endfunction

endpackage

// File: rtl/ika87ad_irq_chan.sv
// One interrupt channel: tick-sampled flag, previous sample, in-service bit.
// Ports: clk/rst_n, set_tick, irq, auto_clr, man_clr, isv_set -> flag, inservice.
module ika87ad_irq_chan #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_tick,
  input  logic irq,
  input  logic auto_clr,
  input  logic man_clr,
  input  logic isv_set,
  output logic flag,
  output logic inservice
);

  logic prev;
  logic set_hit;

  // Edge channels need a low sample before the next rising sample.
  assign set_hit = set_tick & irq & (~EDGE | ~prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag      <= 1'b0;
      prev      <= 1'b0;
      inservice <= 1'b0;
    end else begin
      if (set_tick)
        prev <= irq;
      // A set on the same edge as a clear wins so no event is lost.
      if (set_hit)
        flag <= 1'b1;
      else if (auto_clr | man_clr)
        flag <= 1'b0;
      if (isv_set)
        inservice <= 1'b1;
      else if (man_clr)
        inservice <= 1'b0;
    end
  end

endmodule

// File: rtl/ika87ad_irq_arbiter.sv
// Interrupt flag bank with fixed-priority arbiter and vector handshake.
// Ports: i_EMUCLK/i_MRST_n, tick strobes, requests, acks -> req, code, flags.
module ika87ad_irq_arbiter
  import ika87ad_irq_pkg::*;
#(
  parameter int                NCH       = NCH_DEF,
  parameter int                CODEW     = CODEW_DEF,
  parameter int unsigned       CODE_BASE = 0,
  parameter logic [NCH-1:0]    EDGE_MASK = '0
) (
  input  logic             i_EMUCLK,
  input  logic             i_MRST_n,
  input  logic             i_SETTICK,
  input  logic             i_RSTTICK,
  input  logic [NCH-1:0]   i_IRQ,
  input  logic [NCH-1:0]   i_ENABLE,
  input  logic [NCH-1:0]   i_MANUAL_MODE,
  input  logic             i_GIE,
  input  logic             i_VEC_ACK,
  input  logic             i_MANUAL_ACK,
  input  logic [CODEW-1:0] i_ACK_CODE,
  output logic             o_IRQ_REQ,
  output logic [CODEW-1:0] o_IRQ_CODE,
  output logic [NCH-1:0]   o_FLAGS,
  output logic [NCH-1:0]   o_INSERVICE
);

  localparam int IW = $clog2(NCH);

  irq_state_e     state;
  logic [IW-1:0]  held_idx;
  logic [IW-1:0]  win;
  logic           any_elig;
  logic [NCH-1:0] blocked;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] auto_clr;
  logic [NCH-1:0] man_clr;
  logic [NCH-1:0] isv_set;
  logic           fetch;
  logic           withdraw;

  assign fetch = (state == IRQ_HELD) & i_VEC_ACK;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic hit;
    assign hit         = fetch & (held_idx == IW'(k));
    assign auto_clr[k] = hit & ~i_MANUAL_MODE[k];
    assign isv_set[k]  = hit & i_MANUAL_MODE[k];
    assign man_clr[k]  = i_RSTTICK & i_MANUAL_ACK &
                         code_hit(32'(i_ACK_CODE), CODE_BASE, k);

    ika87ad_irq_chan #(
      .EDGE (EDGE_MASK[k])
    ) u_chan (
      .clk       (i_EMUCLK),
      .rst_n     (i_MRST_n),
      .set_tick  (i_SETTICK),
      .irq       (i_IRQ[k]),
      .auto_clr  (auto_clr[k]),
      .man_clr   (man_clr[k]),
      .isv_set   (isv_set[k]),
      .flag      (o_FLAGS[k]),
      .inservice (o_INSERVICE[k])
    );
  end

  // A channel in service masks itself and everything of lower priority.
  always_comb begin
    logic run;
    run = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      run        = run | o_INSERVICE[k];
      blocked[k] = run;
    end
  end

  assign elig     = o_FLAGS & i_ENABLE & ~blocked;
  assign any_elig = |elig;

  always_comb begin
    win = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (elig[k])
        win = IW'(k);
  end

  assign withdraw = ~i_GIE | ~o_FLAGS[held_idx] | ~i_ENABLE[held_idx];

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state      <= IRQ_IDLE;
      held_idx   <= '0;
      o_IRQ_REQ  <= 1'b0;
      o_IRQ_CODE <= '0;
    end else begin
      unique case (state)
        IRQ_IDLE: begin
          if (i_GIE & any_elig) begin
            held_idx   <= win;
            o_IRQ_CODE <= CODEW'(CODE_BASE + 32'(win));
            o_IRQ_REQ  <= 1'b1;
            state      <= IRQ_HELD;
          end
        end
        IRQ_HELD: begin
          // The ack is honoured even when a withdraw coincides.
          if (i_VEC_ACK | withdraw) begin
            o_IRQ_REQ <= 1'b0;
            state     <= IRQ_IDLE;
          end
        end
        default: begin
          o_IRQ_REQ <= 1'b0;
          state     <= IRQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ika87ad_irq_arbiter.sv
// Scoreboard bench for the interrupt arbiter against a behavioural model.
// Driver pushes expected post-edge state; monitor pops and compares.
module tb_ika87ad_irq_arbiter;

  localparam int NCH   = 8;
  localparam int CODEW = 5;
  localparam int CB    = 0;
  localparam logic [NCH-1:0] EM = 8'h81;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic settick = 0, rsttick = 0, gie = 0, vack = 0, mack = 0;
  logic [NCH-1:0] irq = '0, en = '0, man = '0;
  logic [CODEW-1:0] ackc = '0;
  logic req;
  logic [CODEW-1:0] code;
  logic [NCH-1:0] flags, insvc;

  always #5 clk = ~clk;

  ika87ad_irq_arbiter #(
    .NCH       (NCH),
    .CODEW     (CODEW),
    .CODE_BASE (CB),
    .EDGE_MASK (EM)
  ) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_SETTICK     (settick),
    .i_RSTTICK     (rsttick),
    .i_IRQ         (irq),
    .i_ENABLE      (en),
    .i_MANUAL_MODE (man),
    .i_GIE         (gie),
    .i_VEC_ACK     (vack),
    .i_MANUAL_ACK  (mack),
    .i_ACK_CODE    (ackc),
    .o_IRQ_REQ     (req),
    .o_IRQ_CODE    (code),
    .o_FLAGS       (flags),
    .o_INSERVICE   (insvc)
  );

  typedef struct {
    int req;
    int code;
    int flags;
    int insvc;
  } snap_t;

  snap_t exp_q[$];
  int tests = 0;
  int fails = 0;

  bit mflag[NCH];
  bit mprev[NCH];
  bit misv[NCH];
  bit mreq;
  int mcode;
  int mheld;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic int vec(input bit a[NCH]);
    int v = 0;
    for (int k = 0; k < NCH; k++)
      if (a[k]) v += (1 << k);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mflag[k] = 0;
      mprev[k] = 0;
      misv[k]  = 0;
    end
    mreq  = 0;
    mcode = 0;
    mheld = 0;
  endtask

  // Apply the rules for one clock edge to the model, using current inputs.
  task automatic model_step();
    int win = -1;
    bit blk = 0;
    bit fetch;
    bit nf[NCH], np[NCH], ni[NCH];
    logic [NCH-1:0] em = EM;
    for (int k = 0; k < NCH; k++) begin
      blk = blk | misv[k];
      if (win < 0 && mflag[k] && en[k] && !blk) win = k;
    end
    fetch = mreq && vack;
    for (int k = 0; k < NCH; k++) begin
      bit s, mc, ac, is;
      s  = settick && irq[k] && (!em[k] || !mprev[k]);
      mc = rsttick && mack && (int'(ackc) == CB + k);
      ac = fetch && mheld == k && !man[k];
      is = fetch && mheld == k && man[k];
      nf[k] = s ? 1'b1 : ((ac || mc) ? 1'b0 : mflag[k]);
      np[k] = settick ? irq[k] : mprev[k];
      ni[k] = is ? 1'b1 : (mc ? 1'b0 : misv[k]);
    end
    if (!mreq) begin
      if (gie && win >= 0) begin
        mreq  = 1;
        mcode = CB + win;
        mheld = win;
      end
    end else if (vack || !gie || !mflag[mheld] || !en[mheld]) begin
      mreq = 0;
    end
    mflag = nf;
    mprev = np;
    misv  = ni;
  endtask

  task automatic tick();
    snap_t s;
    model_step();
    s.req   = int'(mreq);
    s.code  = mcode;
    s.flags = vec(mflag);
    s.insvc = vec(misv);
    exp_q.push_back(s);
    @(posedge clk);
    @(negedge clk);
    settick = 0;
    rsttick = 0;
    vack    = 0;
    mack    = 0;
  endtask

  task automatic sample(input logic [NCH-1:0] v);
    irq = v;
    settick = 1;
    tick();
  endtask

  task automatic ack();
    vack = 1;
    tick();
  endtask

  always @(posedge clk) begin
    snap_t s;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("req", 32'(req), s.req);
      check("code", 32'(code), s.code);
      check("flags", 32'(flags), s.flags);
      check("inservice", 32'(insvc), s.insvc);
    end
  end

  initial begin
    #2 rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(req), 0);
    check("rst_code", 32'(code), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_insvc", 32'(insvc), 0);
    rst_n = 1;
    en = '1;
    gie = 1;
    man = '0;
    @(negedge clk);

    // level channel 2 with auto ack
    sample(8'h04);
    irq = '0;
    tick();
    ack();
    tick();

    // edge channel 0 held high across ticks
    for (int i = 0; i < 3; i++) begin
      sample(8'h01);
      tick();
      if (mreq) ack();
    end
    sample(8'h00);
    sample(8'h01);
    tick();
    ack();
    sample(8'h00);

    // simultaneous ch5 and ch1
    sample(8'h22);
    irq = '0;
    tick();
    ack();
    tick();
    ack();
    tick();

    // manual ch3 nesting
    man = 8'h08;
    sample(8'h08);
    irq = '0;
    tick();
    ack();
    sample(8'h10);
    irq = '0;
    tick();
    tick();
    sample(8'h02);
    irq = '0;
    tick();
    ack();
    ackc = 5'd3;
    rsttick = 1;
    mack = 1;
    tick();
    tick();
    ack();
    tick();
    man = '0;

    // GIE withdraw and set/clear collision on ch6
    sample(8'h40);
    irq = '0;
    tick();
    gie = 0;
    tick();
    gie = 1;
    tick();
    vack = 1;
    sample(8'h40);
    irq = '0;
    tick();
    tick();
    ack();
    tick();

    // async reset while a vector is held
    sample(8'h40);
    irq = '0;
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    check("arst_req", 32'(req), 0);
    check("arst_code", 32'(code), 0);
    check("arst_flags", 32'(flags), 0);
    check("arst_insvc", 32'(insvc), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      irq     = NCH'($urandom);
      settick = ($urandom_range(0, 1) == 1);
      rsttick = ($urandom_range(0, 2) == 0);
      mack    = ($urandom_range(0, 2) == 0);
      ackc    = ($urandom_range(0, 7) == 0) ? CODEW'($urandom)
                                            : CODEW'($urandom_range(0, 9));
      en      = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
      if ($urandom_range(0, 15) == 0) man = NCH'($urandom);
      gie     = ($urandom_range(0, 9) != 0);
      vack    = mreq ? ($urandom_range(0, 1) == 1)
                     : ($urandom_range(0, 9) == 0);
      tick();
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
